// File: rtl/prefetch_pkg.sv
// Shared constants for the three-channel prefetch controller: channel indices,
// per-channel state encoding and status-vector bit positions.
package prefetch_pkg;

  localparam int CH_FIR = 2;
  localparam int CH_QS  = 1;
  localparam int CH_MM  = 0;
  localparam int NUM_CH = 3;

  localparam int unsigned BURST_LEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StFill  = 2'd2,
    StReady = 2'd3
  } chan_state_e;

  // Each channel owns two adjacent bits of state_reg: {full, empty}.
  localparam int ST_EMPTY_OFS = 0;
  localparam int ST_FULL_OFS  = 1;

  function automatic int status_bit(input int ch, input int ofs);
    return 2 * ch + ofs;
  endfunction

endpackage

// File: rtl/prefetch_chan_fsm.sv
// One prefetch channel: IDLE/WAIT/FILL/READY sequencing, head/base addresses,
// buffer occupancy count and burst beat index.
module prefetch_chan_fsm
  import prefetch_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [29:0] i_word_addr,
  input  logic        i_grant,
  input  logic        i_ack,
  output logic        o_stall,
  output logic        o_hit,
  output logic        o_valid,
  output logic        o_wait,
  output logic        o_fill,
  output logic [31:0] o_base_addr,
  output logic [3:0]  o_mis_index,
  output logic        o_full,
  output logic        o_empty
);

  localparam int unsigned CntW = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(BURST_LEN);
  localparam logic [3:0]      LastBeat = 4'(BURST_LEN - 1);

  chan_state_e     r_state;
  logic [29:0]     r_head;
  logic [29:0]     r_base;
  logic [CntW-1:0] r_count;
  logic [3:0]      r_beat;
  logic            r_valid;
  logic            w_hit;

  assign w_hit = !rst && (r_state == StReady) && i_req && (r_count != '0) &&
                 (i_word_addr == r_head);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_head  <= '0;
      r_base  <= '0;
      r_count <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
    end else begin
      // Buffer output register: data for a hit appears one cycle later.
      r_valid <= w_hit;
      unique case (r_state)
        StIdle: begin
          if (i_req) begin
            r_base  <= i_word_addr;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (i_grant) begin
            r_beat  <= '0;
            r_state <= StFill;
          end
        end
        StFill: begin
          if (i_ack) begin
            if (r_beat == LastBeat) begin
              r_beat  <= '0;
              r_count <= FullCnt;
              r_head  <= r_base;
              r_state <= StReady;
            end else begin
              r_beat <= r_beat + 4'd1;
            end
          end
        end
        StReady: begin
          if (w_hit) begin
            r_head  <= r_head + 30'd1;
            r_count <= r_count - CntW'(1);
            if (r_count == CntW'(1)) r_state <= StIdle;
          end else if (i_req) begin
            // Miss: drop the stale buffer and refetch from the new address.
            r_base  <= i_word_addr;
            r_count <= '0;
            r_state <= StWait;
          end
        end
      endcase
    end
  end

  assign o_hit       = w_hit;
  assign o_stall     = !rst && i_req && !w_hit;
  assign o_valid     = !rst && r_valid;
  assign o_wait      = !rst && (r_state == StWait);
  assign o_fill      = !rst && (r_state == StFill);
  assign o_base_addr = rst ? 32'd0 : {r_base, 2'b00};
  assign o_mis_index = rst ? 4'd0 : r_beat;
  assign o_full      = !rst && (r_state == StReady) && (r_count == FullCnt);
  assign o_empty     = rst || (r_count == '0);

endmodule

// File: rtl/prefetch_ctrl.sv
// Three-channel prefetch controller: per-channel FSMs sharing one SDRAM burst
// port, arbitrated with fixed priority FIR > QS > MM.
module prefetch_ctrl
  import prefetch_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rd_req,
  input  logic [31:0] rd_addr,
  output logic [2:0]  rd_stall,
  output logic [2:0]  rd_valid,
  output logic [2:0]  hit,
  output logic [2:0]  burst_req,
  output logic [31:0] burst_addr,
  input  logic        sdram_ack,
  output logic [2:0]  f_ack,
  output logic [3:0]  mis_index_fir,
  output logic [3:0]  mis_index_qs,
  output logic [3:0]  mis_index_mm,
  output logic [5:0]  state_reg
);

  logic [NUM_CH-1:0] w_wait;
  logic [NUM_CH-1:0] w_fill;
  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [31:0]       w_base [NUM_CH];
  logic [3:0]        w_mis  [NUM_CH];
  logic [1:0]        w_unused_addr;

  assign w_unused_addr = rd_addr[1:0];

  // A new burst is granted only while no channel is filling, so at most one
  // channel ever owns the SDRAM port.
  always_comb begin
    w_grant = '0;
    if (w_fill == '0) begin
      if (w_wait[CH_FIR])     w_grant[CH_FIR] = 1'b1;
      else if (w_wait[CH_QS]) w_grant[CH_QS]  = 1'b1;
      else if (w_wait[CH_MM]) w_grant[CH_MM]  = 1'b1;
    end
  end

  always_comb begin
    burst_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_fill[c]) burst_addr = w_base[c];
    end
  end

  assign burst_req = w_fill;
  assign f_ack     = {3{sdram_ack}} & w_fill;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    prefetch_chan_fsm #(
      .BURST_LEN (BURST_LEN)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .i_req       (rd_req[c]),
      .i_word_addr (rd_addr[31:2]),
      .i_grant     (w_grant[c]),
      .i_ack       (f_ack[c]),
      .o_stall     (rd_stall[c]),
      .o_hit       (hit[c]),
      .o_valid     (rd_valid[c]),
      .o_wait      (w_wait[c]),
      .o_fill      (w_fill[c]),
      .o_base_addr (w_base[c]),
      .o_mis_index (w_mis[c]),
      .o_full      (w_full[c]),
      .o_empty     (w_empty[c])
    );

    assign state_reg[status_bit(c, ST_FULL_OFS)]  = w_full[c];
    assign state_reg[status_bit(c, ST_EMPTY_OFS)] = w_empty[c];
  end

  assign mis_index_fir = w_mis[CH_FIR];
  assign mis_index_qs  = w_mis[CH_QS];
  assign mis_index_mm  = w_mis[CH_MM];

endmodule

// File: doc/prefetch_ctrl.md
PREFETCH_CTRL -- requirements
Module: prefetch_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, words per prefetch burst; legal values are powers of two up to 16.
REQ-002 SHALL have port clk  in  1  clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-004 SHALL have port rd_req  in  3  one-hot read request per channel: [2] FIR, [1] QS, [0] MM.
REQ-005 SHALL have port rd_addr  in  32  byte address of the request; bits [1:0] are ignored.
REQ-006 SHALL have port rd_stall  out  3  per channel: request not served this cycle.
REQ-007 SHALL have port rd_valid  out  3  per channel: prefetch buffer data_out is valid this cycle.
REQ-008 SHALL have port hit  out  3  per channel: shift strobe to the prefetch buffer (its HIT).
REQ-009 SHALL have port burst_req  out  3  one-hot per channel: SDRAM burst owner.
REQ-010 SHALL have port burst_addr  out  32  word-aligned start address of the active burst.
REQ-011 SHALL have port sdram_ack  in  1  one data beat delivered by SDRAM this cycle.
REQ-012 SHALL have port f_ack  out  3  per channel: beat strobe to the buffer; equals {3{sdram_ack}} & burst_req.
REQ-013 SHALL have ports mis_index_fir, mis_index_qs, mis_index_mm  out  4 each  buffer write index per channel.
REQ-014 SHALL have port state_reg  out  6  {FIR full, FIR empty, QS full, QS empty, MM full, MM empty}.

Function
REQ-015 SHALL keep per-channel state: IDLE, WAIT, FILL, READY; plus head_addr (32 bits), base_addr (32 bits), count (0..BURST_LEN) and beat index (4 bits).
REQ-016 SHALL, in IDLE, on rd_req[c]: set base_addr = {rd_addr[31:2], 2'b00}, assert rd_stall[c], and go to WAIT.
REQ-017 SHALL, in READY, treat rd_req[c] as a hit when count > 0 and rd_addr[31:2] == head_addr[31:2].
REQ-018 SHALL, on a hit: assert hit[c] combinationally in the same cycle, set head_addr += 4 and count -= 1, and assert rd_valid[c] the following cycle (the buffer's registered output latency is 1 cycle).
REQ-019 SHALL, in READY, treat any rd_req[c] that is not a hit as a miss: rd_stall[c] = 1, base_addr is reloaded from rd_addr, and the state goes to WAIT; the old contents are discarded.
REQ-020 SHALL, in READY, go to IDLE when a hit drives count to 0.
REQ-021 SHALL, in WAIT, grant the SDRAM port when no burst is active, using fixed priority FIR > QS > MM; the granted channel goes to FILL with beat index 0.
REQ-022 SHALL, in FILL: hold burst_req[c] = 1 and burst_addr = base_addr; drive mis_index = beat index; increment the index on each sdram_ack.
REQ-023 SHALL, on the beat with index BURST_LEN-1, release burst_req the next cycle and go to READY with count = BURST_LEN and head_addr = base_addr.
REQ-024 SHALL assert rd_stall[c] and never hit[c] for any rd_req[c] in WAIT or FILL, so a shift never coincides with a beat write to the same channel.
REQ-025 SHALL allow hits on one channel while another channel is in FILL.
REQ-026 SHALL ignore sdram_ack when no burst is active (f_ack = 0).
REQ-027 SHALL drive full[c] = (READY && count == BURST_LEN) and empty[c] = (count == 0) into state_reg.

Reset
REQ-028 SHALL, while rst is high, put all channels in IDLE and clear count, indices and addresses.
REQ-029 SHALL hold all outputs at 0 during reset except state_reg, which is 6'b010101.
REQ-030 SHALL abandon a burst in progress on reset without further f_ack; the SDRAM side is reset by the same rst.

Structure
REQ-031 SHALL place the following in package prefetch_pkg: channel indices CH_FIR=2, CH_QS=1, CH_MM=0; the state encoding; BURST_LEN default; status bit positions.
REQ-032 SHALL implement the per-channel FSM, counters and address registers as sub-module prefetch_chan_fsm, instantiated 3 times; arbitration and the burst-beat mux live in the top level.

Verification
REQ-033 SHALL cover cold miss: rd_req[2] at 0x100 -> burst_req=3'b100 and burst_addr=0x100; after 8 sdram_ack, mis_index_fir has stepped 0..7 and state_reg[5:4]=2'b10.
REQ-034 SHALL cover sequential hits: FIR READY at 0x100; requests at 0x100, 0x104 -> hit[2] in each cycle and rd_valid[2] one cycle later; after 8 hits, state_reg[4]=1 and the state is IDLE.
REQ-035 SHALL cover non-sequential miss: FIR READY with head 0x104; request at 0x200 -> rd_stall[2]=1 and a new burst with burst_addr=0x200.
REQ-036 SHALL cover simultaneous misses: rd_req=3'b111 from IDLE -> bursts are served in the order FIR, QS, MM, and burst_req is never multi-hot.
REQ-037 SHALL cover hit during another fill: QS filling while FIR is READY -> FIR hits proceed, and f_ack[2] stays 0.
REQ-038 SHALL cover reset mid-burst: rst after 3 beats -> burst_req=0, state_reg=6'b010101, and later sdram_ack produces f_ack=0.
